// File: rtl/spi_master_pkg.sv
// Shared types and sizing helpers for the spi_master block.
// FSM states are plain localparam codes so legacy tooling can decode them.
package spi_master_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } OP_e;

    typedef logic [2:0] MSTATE_e;

    localparam MSTATE_e M_IDLE    = 3'd0;
    localparam MSTATE_e M_SEL     = 3'd1;
    localparam MSTATE_e M_CMD     = 3'd2;
    localparam MSTATE_e M_SHIFT   = 3'd3;
    localparam MSTATE_e M_WAIT    = 3'd4;
    localparam MSTATE_e M_CAPTURE = 3'd5;
    localparam MSTATE_e M_GAP     = 3'd6;

    localparam int ADDR_SIZE_DEF = 8;

    function automatic int frame_w(input int addr_size);
        return addr_size + 2;
    endfunction

    localparam int FRAME_W = frame_w(ADDR_SIZE_DEF);

endpackage

// File: rtl/spi_master_if.sv
// Host/link bundle for spi_master. 'master' is the SPI master's own view,
// 'slave' is the view of whoever drives commands and MISO (host, bench, slave).
interface spi_master_if #(
    parameter int ADDR_SIZE = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [ADDR_SIZE-1:0] cmd_data;
    logic                 SS_n;
    logic                 MOSI;
    logic                 MISO;
    logic                 rd_valid;
    logic [ADDR_SIZE-1:0] rd_data;
    logic                 busy;
    logic                 proto_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, MISO,
        output cmd_ready, SS_n, MOSI, rd_valid, rd_data, busy, proto_err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, MISO,
        input  cmd_ready, SS_n, MOSI, rd_valid, rd_data, busy, proto_err
    );
endinterface

// File: rtl/spi_master_shreg.sv
// Datapath for spi_master: loadable MSB-first shift-out frame register,
// MSB-first shift-in capture register and the shared per-state bit counter.
module spi_master_shreg
    import spi_master_pkg::*;
#(
    parameter int FW    = FRAME_W,
    parameter int AS    = ADDR_SIZE_DEF,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [FW-1:0]    frame,
    input  logic             shift,
    input  logic             cap,
    input  logic             miso,
    input  logic             cnt_clr,
    input  logic             cnt_en,
    output logic             msb,
    output logic [AS-1:0]    cap_next,
    output logic [CNT_W-1:0] cnt
);
    logic [FW-1:0] sreg;
    // Only AS-1 bits are stored; the final bit goes straight into cap_next.
    logic [AS-2:0] ireg;

    assign msb      = sreg[FW-1];
    assign cap_next = {ireg, miso};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            ireg <= '0;
            cnt  <= '0;
        end else begin
            if (ld)
                sreg <= frame;
            else if (shift)
                sreg <= {sreg[FW-2:0], 1'b0};

            if (ld)
                ireg <= '0;
            else if (cap)
                ireg <= cap_next[AS-2:0];

            if (ld || cnt_clr)
                cnt <= '0;
            else if (cnt_en)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI-to-RAM link initiator: frames one command per handshake onto SS_n/MOSI
// and captures the read-data reply. Optional SPI_MASTER_PROTOCOL_CHECK_EN adds op-sequence checking.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int ADDR_SIZE   = 8,
    parameter int TURN_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input logic          clk,
    input logic          rst,
    spi_master_if.master bus
);
    localparam int FW    = frame_w(ADDR_SIZE);
    localparam int CNT_W = $clog2(FW + ADDR_SIZE + TURN_CYCLES + GAP_CYCLES + 1);

    MSTATE_e              state, state_nx;
    OP_e                  op_q;
    logic                 ss_n_q, ss_n_nx, mosi_q, mosi_nx, rdv_q, rdv_nx, rdy_q;
    logic [ADDR_SIZE-1:0] rdd_q, rdd_nx, cap_next;
    logic                 accept, ld, shift, cap, cnt_clr, cnt_en, msb;
    logic [CNT_W-1:0]     cnt;

    assign accept = bus.cmd_valid & rdy_q;

    spi_master_shreg #(
        .FW   (FW),
        .AS   (ADDR_SIZE),
        .CNT_W(CNT_W)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .ld      (accept),
        .frame   ({bus.cmd_op, bus.cmd_data}),
        .shift   (shift),
        .cap     (cap),
        .miso    (bus.MISO),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .msb     (msb),
        .cap_next(cap_next),
        .cnt     (cnt)
    );

    assign ld = accept;

    always_comb begin
        state_nx = state;
        shift    = 1'b0;
        cap      = 1'b0;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        ss_n_nx  = ss_n_q;
        mosi_nx  = 1'b0;
        rdv_nx   = 1'b0;
        rdd_nx   = rdd_q;
        case (state)
            M_IDLE: begin
                ss_n_nx = 1'b1;
                if (ld) begin
                    ss_n_nx  = 1'b0;
                    state_nx = M_SEL;
                end
            end
            M_SEL: begin
                mosi_nx  = msb;
                state_nx = M_CMD;
            end
            // The command cycle repeats the first frame bit before shifting starts.
            M_CMD: begin
                mosi_nx  = msb;
                shift    = 1'b1;
                cnt_clr  = 1'b1;
                state_nx = M_SHIFT;
            end
            M_SHIFT: begin
                if (cnt == CNT_W'(FW - 1)) begin
                    cnt_clr = 1'b1;
                    if (op_q == RD_DATA) begin
                        state_nx = (TURN_CYCLES == 0) ? M_CAPTURE : M_WAIT;
                    end else begin
                        ss_n_nx  = 1'b1;
                        state_nx = M_GAP;
                    end
                end else begin
                    mosi_nx = msb;
                    shift   = 1'b1;
                    cnt_en  = 1'b1;
                end
            end
            M_WAIT: begin
                if (cnt == CNT_W'(TURN_CYCLES - 1)) begin
                    cnt_clr  = 1'b1;
                    state_nx = M_CAPTURE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            M_CAPTURE: begin
                cap = 1'b1;
                if (cnt == CNT_W'(ADDR_SIZE - 1)) begin
                    cnt_clr  = 1'b1;
                    ss_n_nx  = 1'b1;
                    rdv_nx   = 1'b1;
                    rdd_nx   = cap_next;
                    state_nx = M_GAP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            M_GAP: begin
                ss_n_nx = 1'b1;
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_clr  = 1'b1;
                    state_nx = M_IDLE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: begin
                ss_n_nx  = 1'b1;
                state_nx = M_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= M_IDLE;
            op_q   <= WR_ADDR;
            ss_n_q <= 1'b1;
            mosi_q <= 1'b0;
            rdv_q  <= 1'b0;
            rdd_q  <= '0;
            rdy_q  <= 1'b1;
        end else begin
            state  <= state_nx;
            ss_n_q <= ss_n_nx;
            mosi_q <= mosi_nx;
            rdv_q  <= rdv_nx;
            rdd_q  <= rdd_nx;
            rdy_q  <= (state_nx == M_IDLE);
            if (accept)
                op_q <= OP_e'(bus.cmd_op);
        end
    end

    assign bus.cmd_ready = rdy_q;
    assign bus.busy      = ~rdy_q;
    assign bus.SS_n      = ss_n_q;
    assign bus.MOSI      = mosi_q;
    assign bus.rd_valid  = rdv_q;
    assign bus.rd_data   = rdd_q;

`ifdef SPI_MASTER_PROTOCOL_CHECK_EN
    // Only "last was WR_ADDR/RD_ADDR" matters, so RD_DATA doubles as "none".
    OP_e  last_op;
    logic perr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_op <= RD_DATA;
            perr_q  <= 1'b0;
        end else begin
            perr_q <= 1'b0;
            if (accept) begin
                last_op <= OP_e'(bus.cmd_op);
                perr_q  <= ((OP_e'(bus.cmd_op) == WR_DATA) && (last_op != WR_ADDR)) ||
                           ((OP_e'(bus.cmd_op) == RD_DATA) && (last_op != RD_ADDR));
            end
        end
    end

    assign bus.proto_err = perr_q;
`else
    assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master; expectations come from a frame-level
// model (frame bit list, window lengths, RAM behind the slave) held in the bench.
module tb_spi_master;
    localparam int AS    = 8;
    localparam int TURN  = 2;
    localparam int GAP   = 1;
    localparam int FW    = AS + 2;
    localparam int END_W = FW + 2;           // edge index where SS_n rises for non-read frames
    localparam int END_R = END_W + TURN + AS; // same for read-data frames

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [AS-1:0] ram [0:(1<<AS)-1];
    logic [AS-1:0] wa, ra, last_rd;
    int            last_op;

    spi_master_if #(.ADDR_SIZE(AS)) bus ();

    spi_master #(
        .ADDR_SIZE  (AS),
        .TURN_CYCLES(TURN),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, " SS_n"}, 32'(bus.SS_n), 32'd1);
        chk({tag, " MOSI"}, 32'(bus.MOSI), 32'd0);
        chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, " busy"}, 32'(bus.busy), 32'd0);
        chk({tag, " rd_valid"}, 32'(bus.rd_valid), 32'd0);
        chk({tag, " proto_err"}, 32'(bus.proto_err), 32'd0);
    endtask

    // Sends one command and checks every cycle of its frame; abort_at>=0 fires rst at that edge.
    task automatic run_cmd(input logic [1:0] op, input logic [AS-1:0] d, input bit noise,
                           input int abort_at);
        logic [FW-1:0] f;
        logic [AS-1:0] rbyte;
        logic          exp_err, exp_mosi;
        int            endk, n;
        string         t;
        f     = {op, d};
        endk  = (op == 2'b11) ? END_R : END_W;
        rbyte = (op == 2'b11) ? ram[ra] : '0;
`ifdef SPI_MASTER_PROTOCOL_CHECK_EN
        exp_err = ((op == 2'b01) && (last_op != 0)) || ((op == 2'b11) && (last_op != 2));
`else
        exp_err = 1'b0;
`endif
        last_op = int'(op);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n), 32'd0);
        tick();
        for (int k = 0; k <= endk + 1; k++) begin
            if (k > 0) tick();
            t = $sformatf("op%0d k%0d", op, k);
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                idle_checks({t, " abort"});
                chk({t, " abort rd_data"}, 32'(bus.rd_data), 32'd0);
                bus.cmd_valid = 1'b0;
                last_rd = '0;
                last_op = -1;
                tick();
                rst = 1'b0;
                return;
            end
            if (noise && k < endk) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_op    = 2'($urandom);
                bus.cmd_data  = AS'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            if (k == 1)                  exp_mosi = f[FW-1];
            else if (k >= 2 && k <= FW+1) exp_mosi = f[FW+1-k];
            else                          exp_mosi = 1'b0;
            chk({t, " SS_n"}, 32'(bus.SS_n), 32'(k >= endk));
            chk({t, " MOSI"}, 32'(bus.MOSI), 32'(exp_mosi));
            chk({t, " busy"}, 32'(bus.busy), 32'(k <= endk));
            chk({t, " cmd_ready"}, 32'(bus.cmd_ready), 32'(k > endk));
            chk({t, " rd_valid"}, 32'(bus.rd_valid), 32'(op == 2'b11 && k == endk));
            chk({t, " rd_data"}, 32'(bus.rd_data),
                32'((op == 2'b11 && k >= endk) ? rbyte : last_rd));
            chk({t, " proto_err"}, 32'(bus.proto_err), 32'(k == 0 ? exp_err : 1'b0));
            // Present each reply bit ahead of the edge that samples it; noise elsewhere.
            if (op == 2'b11 && k >= END_W + TURN && k < endk)
                bus.MISO = rbyte[endk-1-k];
            else
                bus.MISO = 1'($urandom);
        end
        case (op)
            2'b00:   wa = d;
            2'b01:   ram[wa] = d;
            2'b10:   ra = d;
            default: last_rd = rbyte;
        endcase
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        bus.MISO      = 1'b0;
        for (int i = 0; i < (1 << AS); i++) ram[i] = AS'($urandom);
        wa = '0;
        ra = '0;
        last_rd = '0;
        last_op = -1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            tick();
            idle_checks($sformatf("reset c%0d", i));
            chk("reset rd_data", 32'(bus.rd_data), 32'd0);
        end

        // read-data straight after reset: sequence violation when checking is built in
        run_cmd(2'b11, 8'h00, 1'b0, -1);
        // write 0xA5 to 0x3C and read it back
        run_cmd(2'b00, 8'h3C, 1'b0, -1);
        run_cmd(2'b01, 8'hA5, 1'b0, -1);
        run_cmd(2'b10, 8'h3C, 1'b0, -1);
        run_cmd(2'b11, 8'h00, 1'b0, -1);
        // reply pattern 1,0,1,1,0,0,1,0
        run_cmd(2'b00, 8'h77, 1'b0, -1);
        run_cmd(2'b01, 8'hB2, 1'b0, -1);
        run_cmd(2'b10, 8'h77, 1'b0, -1);
        run_cmd(2'b11, 8'h00, 1'b1, -1);
        // all-zero reply still completes
        run_cmd(2'b00, 8'h10, 1'b0, -1);
        run_cmd(2'b01, 8'h00, 1'b0, -1);
        run_cmd(2'b10, 8'h10, 1'b0, -1);
        run_cmd(2'b11, 8'hFF, 1'b0, -1);
        // reset mid-frame, then a clean frame
        run_cmd(2'b00, 8'h5A, 1'b0, 7);
        run_cmd(2'b00, 8'hC3, 1'b0, -1);

        for (int i = 0; i < 40; i++)
            run_cmd(2'($urandom), AS'($urandom), 1'($urandom), -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Initiator for the single-wire-per-direction SPI-to-RAM link. The link is clocked by the system clock; there is no separate SCLK.
- Accepts one RAM command per handshake, frames it onto SS_n/MOSI, and captures the 8-bit read-data reply from MISO.
- Sits between the bench/host logic and the SPI slave + RAM wrapper; the bench connects its SS_n/MOSI/MISO directly to the slave.

Parameters:
- ADDR_SIZE, 8, width of the data/address payload; frame length is ADDR_SIZE+2.
- TURN_CYCLES, 2, cycles between the last MOSI bit and the first MISO sampling window of a read-data frame.
- GAP_CYCLES, 1, minimum SS_n-high cycles between frames (must be >=1).

Ports:
- clk  in  1  system clock; all activity on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- cmd_data  in  ADDR_SIZE  address or data payload.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to the slave.
- MISO  in  1  serial data from the slave.
- rd_valid  out  1  one-cycle pulse when rd_data is valid.
- rd_data  out  ADDR_SIZE  captured read byte.
- busy  out  1  high whenever not in IDLE.
- proto_err  out  1  sequence-violation pulse; tied 0 unless the optional feature is compiled in.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): state=IDLE, SS_n=1, MOSI=0, rd_valid=0, rd_data=0, proto_err=0, counters=0. Any partially sent frame is abandoned.
- Frame word: F = {cmd_op, cmd_data}, ADDR_SIZE+2 bits, sent MSB first. It is latched on the accept edge (cmd_valid & cmd_ready), called E0.
- All outputs are registered and change on the edge that enters each state.
- IDLE: SS_n=1, MOSI=0. On accept, SS_n<=0 at E0 and go to SEL.
- SEL: 1 cycle; MOSI=0. At E1 go to CMD with MOSI<=F[9].
- CMD: 1 cycle carrying the command bit. At E2 go to SHIFT with MOSI<=F[9].
- SHIFT: 10 cycles; MOSI carries F[9]..F[0], driven on edges E2..E11. At E12:
  - op!=11: go to GAP with SS_n<=1, MOSI<=0.
  - op==11: go to WAIT; SS_n stays low.
- WAIT: TURN_CYCLES cycles; SS_n low, MOSI=0. Exits at E12+TURN_CYCLES (E14 at default).
- CAPTURE: 8 cycles; sample MISO into a shift register MSB first on edges E15..E22 (default timing). At E22: SS_n<=1, rd_data<=assembled byte, rd_valid<=1 for one cycle, go to GAP.
- GAP: SS_n=1 for GAP_CYCLES cycles, then IDLE.
- Frame lengths (default parameters):
  - Write/read-addr: SS_n low 12 cycles; accept-to-next-accept minimum 14 cycles.
  - Read-data: SS_n low 22 cycles.
- cmd_valid while busy is ignored; cmd_op/cmd_data need be stable only on the accept edge.
- rd_valid never asserts for op!=11. rd_data holds its value until the next read-data frame completes.
- A read-data frame with MISO stuck at 0 still completes and returns 0x00; there is no timeout.

Optional Feature:
- Macro: SPI_MASTER_PROTOCOL_CHECK_EN.
- When defined: a 2-bit tracker of the last accepted op. proto_err pulses one cycle after an accept when:
  - op==01 is not immediately preceded by 00, or
  - op==11 is not immediately preceded by 10.
- The tracker resets to "none", so the first command after reset is 00 or 10 if no error is wanted.
- The frame is still sent when proto_err fires.
- When undefined: no tracker; proto_err is constant 0.

Decomposition:
- Add to wrapper_shared_pkg:
  - OP_e enum (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA).
  - MSTATE_e enum (M_IDLE, M_SEL, M_CMD, M_SHIFT, M_WAIT, M_CAPTURE, M_GAP).
  - FRAME_W = ADDR_SIZE+2.
- One natural sub-module: spi_master_shreg, a loadable 10-bit MSB-first shift-out register plus an 8-bit shift-in register with a bit counter. The FSM stays in spi_master.

Test Plan:
- Reset released, no command: SS_n=1, MOSI=0, cmd_ready=1, rd_valid=0 for 20 cycles.
- Write-addr 0x3C: MOSI over E1..E11 = 0,0,0,0,0,1,1,1,1,0,0; SS_n low exactly E0..E12; rd_valid stays 0.
- Write 00/0x3C, then 01/0xA5, read 10/0x3C, then 11/0x00 against the slave+RAM: rd_data=0xA5 with rd_valid pulsing one cycle after E22; SS_n high for >=1 cycle between frames.
- MISO driven 1,0,1,1,0,0,1,0 on E15..E22: rd_data=0xB2.
- rst asserted at E7 of a write: SS_n=1 and MOSI=0 immediately, state IDLE; the next accepted frame is correctly formed.
- With SPI_MASTER_PROTOCOL_CHECK_EN: reset, then 11/0x00 → proto_err pulse, frame still sent. Without the macro: proto_err stays 0.
